// File: rtl/pc_fetch.sv
//------------------------------------------------------------------------------
// pc_fetch : fetch stage owning the PC, single-outstanding imem handshake
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch #(
  parameter int                   CPU_WIDTH = 32,
  parameter logic [CPU_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [CPU_WIDTH-1:0] NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] next_pc,
  output logic                 pc_ena,
  output logic [CPU_WIDTH-1:0] curr_pc,
  input  logic                 flush,
  input  logic [CPU_WIDTH-1:0] flush_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_rsp_valid,
  input  logic [CPU_WIDTH-1:0] imem_rsp_data,
  input  logic                 imem_rsp_err,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [CPU_WIDTH-1:0] inst,
  output logic [CPU_WIDTH-1:0] inst_pc,
  output logic                 inst_fault,
  output logic [31:0]          fetch_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    DROP  = 3'd4
  } state_t;

  state_t r_state;
  logic   w_aligned;
  logic   w_req_fire;

  assign w_aligned      = (curr_pc[1:0] == 2'b00);
  assign imem_req_valid = (r_state == REQ) && w_aligned;
  assign imem_addr      = curr_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;
  assign inst_valid     = (r_state == VALID);
  // The PC only advances through next_pc when decode consumes and no redirect wins.
  assign pc_ena         = (r_state == VALID) && inst_ready && !flush && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      curr_pc    <= RESET_PC;
      fetch_cnt  <= 32'd0;
      inst       <= NOP_INST;
      inst_pc    <= RESET_PC;
      inst_fault <= 1'b0;
    end else if (flush) begin
      curr_pc <= flush_pc;
      // A request already handed to memory must have its response swallowed.
      case (r_state)
        WAIT:    r_state <= imem_rsp_valid ? REQ : DROP;
        DROP:    r_state <= imem_rsp_valid ? REQ : DROP;
        REQ:     r_state <= w_req_fire ? DROP : REQ;
        default: r_state <= REQ;
      endcase
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ: begin
          if (!w_aligned) begin
            inst       <= NOP_INST;
            inst_pc    <= curr_pc;
            inst_fault <= 1'b1;
            r_state    <= VALID;
          end else if (imem_req_ready) begin
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            inst       <= imem_rsp_err ? NOP_INST : imem_rsp_data;
            inst_pc    <= curr_pc;
            inst_fault <= imem_rsp_err;
            r_state    <= VALID;
          end
        end
        VALID: begin
          if (inst_ready) begin
            curr_pc   <= next_pc;
            fetch_cnt <= fetch_cnt + 32'd1;
            r_state   <= REQ;
          end
        end
        DROP: begin
          if (imem_rsp_valid) r_state <= REQ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_fetch.sv
//------------------------------------------------------------------------------
// tb_pc_fetch : directed scoreboard bench for pc_fetch
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] next_pc;
  logic        pc_ena;
  logic [31:0] curr_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic [31:0] fetch_cnt;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .next_pc       (next_pc),
    .pc_ena        (pc_ena),
    .curr_pc       (curr_pc),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_fault    (inst_fault),
    .fetch_cnt     (fetch_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one zero-wait fetch at the expected address and record what decode should see.
  task automatic fetch(input logic [31:0] data, input logic err, input logic [31:0] addr);
    exp_t e;
    int   n = 0;
    imem_req_ready = 1'b1;
    while (!imem_req_valid && n < 10) begin
      tick();
      n++;
    end
    chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("req_addr", imem_addr, addr);
    tick();
    imem_req_ready = 1'b0;
    chk("req_after_accept", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    imem_rsp_err   = err;
    e.inst  = err ? NOP : data;
    e.pc    = addr;
    e.fault = err;
    sb.push_back(e);
    tick();
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'b0;
    chk("inst_valid_latency", {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic consume(input logic [31:0] nxt, input logic [31:0] exp_cnt);
    exp_t e;
    inst_ready = 1'b1;
    next_pc    = nxt;
    #1;
    chk("pc_ena_on_consume", {31'd0, pc_ena}, 32'd1);
    chk("consume_valid", {31'd0, inst_valid}, 32'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("inst", inst, e.inst);
      chk("inst_pc", inst_pc, e.pc);
      chk("inst_fault", {31'd0, inst_fault}, {31'd0, e.fault});
    end
    tick();
    inst_ready = 1'b0;
    chk("pc_ena_pulse_end", {31'd0, pc_ena}, 32'd0);
    chk("curr_pc_adv", curr_pc, nxt);
    chk("fetch_cnt", fetch_cnt, exp_cnt);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_curr_pc"}, curr_pc, 32'h0);
    chk({tag, "_fetch_cnt"}, fetch_cnt, 32'h0);
    chk({tag, "_inst"}, inst, NOP);
    chk({tag, "_inst_pc"}, inst_pc, 32'h0);
    chk({tag, "_inst_fault"}, {31'd0, inst_fault}, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    chk({tag, "_pc_ena"}, {31'd0, pc_ena}, 32'd0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; next_pc = '0; flush = 1'b0; flush_pc = '0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    imem_rsp_err = 1'b0; inst_ready = 1'b0;

    // Reset, then a zero-wait fetch at 0x0.
    tick(); tick();
    chk_reset_state("reset");
    rst = 1'b0;
    tick();
    fetch(32'h00A00093, 1'b0, 32'h0);
    consume(32'h4, 32'd1);

    // Memory stalls acceptance for five cycles.
    imem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("stall_req_addr", imem_addr, 32'h4);
      tick();
    end
    fetch(32'h00200113, 1'b0, 32'h4);
    consume(32'h8, 32'd2);

    // Bus error response at 0x8.
    fetch(32'h12345678, 1'b1, 32'h8);
    consume(32'h20, 32'd3);

    // Flush while a request is outstanding; late response must be dropped.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    flush = 1'b1; flush_pc = 32'h100;
    #1;
    chk("flush_wait_pc_ena", {31'd0, pc_ena}, 32'd0);
    tick();
    flush = 1'b0;
    chk("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("drop_curr_pc", curr_pc, 32'h100);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF;
    tick();
    imem_rsp_valid = 1'b0;
    chk("drop_no_valid", {31'd0, inst_valid}, 32'd0);
    chk("drop_fetch_cnt", fetch_cnt, 32'd3);
    fetch(32'h00300193, 1'b0, 32'h100);
    consume(32'h104, 32'd4);

    // Redirect to a misaligned PC produces a faulting NOP, no request.
    flush = 1'b1; flush_pc = 32'h102;
    tick();
    flush = 1'b0;
    chk("misalign_no_req_a", {31'd0, imem_req_valid}, 32'd0);
    e.inst = NOP; e.pc = 32'h102; e.fault = 1'b1;
    sb.push_back(e);
    tick();
    chk("misalign_no_req_b", {31'd0, imem_req_valid}, 32'd0);
    chk("misalign_valid", {31'd0, inst_valid}, 32'd1);
    consume(32'h200, 32'd5);

    // Flush in VALID with inst_ready high: not consumed.
    fetch(32'h00400213, 1'b0, 32'h200);
    inst_ready = 1'b1; next_pc = 32'h204;
    flush = 1'b1; flush_pc = 32'h300;
    #1;
    chk("flush_valid_pc_ena", {31'd0, pc_ena}, 32'd0);
    sb.delete();
    tick();
    flush = 1'b0; inst_ready = 1'b0;
    chk("flush_valid_drop", {31'd0, inst_valid}, 32'd0);
    chk("flush_valid_cnt", fetch_cnt, 32'd5);
    chk("flush_valid_pc", curr_pc, 32'h300);

    // Flush coinciding with request acceptance must drop the response.
    imem_req_ready = 1'b1;
    flush = 1'b1; flush_pc = 32'h400;
    tick();
    imem_req_ready = 1'b0; flush = 1'b0;
    chk("accflush_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("accflush_curr_pc", curr_pc, 32'h400);
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hCAFEF00D;
    tick();
    imem_rsp_valid = 1'b0;
    chk("accflush_no_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'h00500293, 1'b0, 32'h400);
    consume(32'h404, 32'd6);

    // Reset while waiting on a response; a response right after reset is ignored.
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk_reset_state("rst_wait");
    rst = 1'b0;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hBAD0BAD0;
    tick();
    imem_rsp_valid = 1'b0;
    chk("post_rst_no_valid", {31'd0, inst_valid}, 32'd0);
    fetch(32'h00A00093, 1'b0, 32'h0);
    consume(32'h4, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
